// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hard-wired CPU control sequencer.
// Contents: sequencer state enum, opcode constants, IR field bit positions,
//           and small opcode-class / register-select helper functions.
package cpu_pkg;

  localparam int NREG_DEF = 16;
  localparam int OPW_DEF  = 5;
  localparam int REGW     = 4;

  // IR field positions
  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;

  // Opcodes
  localparam logic [OPW_DEF-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW_DEF-1:0] ALU_MAX = 5'b01100;
  localparam logic [OPW_DEF-1:0] OP_MUL  = 5'b01101;
  localparam logic [OPW_DEF-1:0] OP_DIV  = 5'b01110;
  localparam logic [OPW_DEF-1:0] OP_NOP  = 5'b11000;
  localparam logic [OPW_DEF-1:0] OP_HALT = 5'b11001;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T1W  = 4'd3,
    ST_T2   = 4'd4,
    ST_T3   = 4'd5,
    ST_T4   = 4'd6,
    ST_T5   = 4'd7,
    ST_T6   = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  // Two-operand ALU ops occupy the bottom of the opcode space.
  function automatic logic is_alu(input logic [OPW_DEF-1:0] op);
    return (op <= ALU_MAX);
  endfunction

  // mul/div produce a 64-bit result split across ZLO/ZHI, hence the extra T6.
  function automatic logic is_muldiv(input logic [OPW_DEF-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic [NREG_DEF-1:0] reg_onehot(input logic [REGW-1:0] idx);
    return NREG_DEF'(1) << idx;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Handshake/strobe bundle between the control sequencer and the datapath.
// master: sequencer side (samples start/ir/mem_ready, drives all strobes).
// slave : datapath/bench side (drives start/ir/mem_ready, samples strobes).
interface control_sequencer_if #(
  parameter int NREG = 16,
  parameter int OPW  = 5
);
  logic            start;
  logic [31:0]     ir;
  logic            mem_ready;

  logic [NREG-1:0] r_in;
  logic [NREG-1:0] r_out;
  logic            pc_out, pc_in, pc_inc, mar_in;
  logic            mdr_in, mdr_out, mdr_read, ir_in, y_in;
  logic            zlo_in, zhi_in, zlo_out, zhi_out, hi_in, lo_in;
  logic [OPW-1:0]  op_code;
  logic            run;
  logic            illegal;

  modport master (
    input  start, ir, mem_ready,
    output r_in, r_out, pc_out, pc_in, pc_inc, mar_in,
           mdr_in, mdr_out, mdr_read, ir_in, y_in,
           zlo_in, zhi_in, zlo_out, zhi_out, hi_in, lo_in,
           op_code, run, illegal
  );

  modport slave (
    output start, ir, mem_ready,
    input  r_in, r_out, pc_out, pc_in, pc_inc, mar_in,
           mdr_in, mdr_out, mdr_read, ir_in, y_in,
           zlo_in, zhi_in, zlo_out, zhi_out, hi_in, lo_in,
           op_code, run, illegal
  );
endinterface

// File: rtl/control_sequencer_ir_field_decode.sv
// Splits the IR into opcode and register fields; one-hot decodes Ra/Rb/Rc.
// Ports: ir (in, 32) -> opcode (5), ra_sel/rb_sel/rc_sel (16, one-hot).
// Purely combinational, no state.
module ir_field_decode
  import cpu_pkg::*;
(
  input  logic [31:0]         ir,
  output logic [OPW_DEF-1:0]  opcode,
  output logic [NREG_DEF-1:0] ra_sel,
  output logic [NREG_DEF-1:0] rb_sel,
  output logic [NREG_DEF-1:0] rc_sel
);

  // Low IR bits carry immediates/other fields not used by this sequencer.
  logic unused_ir_low;
  assign unused_ir_low = ^ir[IR_RC_LSB-1:0];

  assign opcode = ir[IR_OP_MSB:IR_OP_LSB];
  assign ra_sel = reg_onehot(ir[IR_RA_MSB:IR_RA_LSB]);
  assign rb_sel = reg_onehot(ir[IR_RB_MSB:IR_RB_LSB]);
  assign rc_sel = reg_onehot(ir[IR_RC_MSB:IR_RC_LSB]);

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired control unit: steps fetch (T0-T2) and execute (T3-T6) from IR,
// waits in T1W for mem_ready, stops in HALT until reset.
// Ports: clk, reset_n (sync active-low), bus (master modport: start/ir/mem_ready in, strobes out).
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int NREG = 16,
  parameter int OPW  = 5
) (
  input  logic clk,
  input  logic reset_n,
  control_sequencer_if.master bus
);

  state_t state, state_nxt;

  logic [OPW_DEF-1:0]  opcode;
  logic [NREG_DEF-1:0] ra_sel, rb_sel, rc_sel;

  ir_field_decode u_dec (
    .ir     (bus.ir),
    .opcode (opcode),
    .ra_sel (ra_sel),
    .rb_sel (rb_sel),
    .rc_sel (rc_sel)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_T0;
      ST_T0:   state_nxt = ST_T1;
      ST_T1:   state_nxt = ST_T1W;
      ST_T1W:  if (bus.mem_ready) state_nxt = ST_T2;
      ST_T2:   state_nxt = ST_T3;
      ST_T3: begin
        if (is_alu(opcode) || is_muldiv(opcode)) state_nxt = ST_T4;
        else if (opcode == OP_HALT)              state_nxt = ST_HALT;
        else                                     state_nxt = ST_T0;  // nop and undefined
      end
      ST_T4:   state_nxt = ST_T5;
      ST_T5:   state_nxt = is_muldiv(opcode) ? ST_T6 : ST_T0;
      ST_T6:   state_nxt = ST_T0;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode. Gated by reset_n so nothing strobes while reset is held,
  // even in the cycle before the reset edge takes the state back to IDLE.
  logic [NREG_DEF-1:0] r_in_c, r_out_c;
  logic [OPW_DEF-1:0]  op_c;

  always_comb begin
    r_in_c       = '0;
    r_out_c      = '0;
    op_c         = '0;
    bus.pc_out   = 1'b0;
    bus.pc_in    = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.mar_in   = 1'b0;
    bus.mdr_in   = 1'b0;
    bus.mdr_out  = 1'b0;
    bus.mdr_read = 1'b0;
    bus.ir_in    = 1'b0;
    bus.y_in     = 1'b0;
    bus.zlo_in   = 1'b0;
    bus.zhi_in   = 1'b0;
    bus.zlo_out  = 1'b0;
    bus.zhi_out  = 1'b0;
    bus.hi_in    = 1'b0;
    bus.lo_in    = 1'b0;
    bus.run      = 1'b0;
    bus.illegal  = 1'b0;

    if (reset_n) begin
      bus.run = (state != ST_IDLE) && (state != ST_HALT);
      unique case (state)
        ST_T0: begin
          bus.pc_out = 1'b1;
          bus.mar_in = 1'b1;
          bus.pc_inc = 1'b1;
          bus.zlo_in = 1'b1;
        end
        ST_T1: begin
          bus.zlo_out  = 1'b1;
          bus.pc_in    = 1'b1;
          bus.mdr_read = 1'b1;
        end
        ST_T1W: begin
          bus.mdr_read = 1'b1;
          bus.mdr_in   = bus.mem_ready;
        end
        ST_T2: begin
          bus.mdr_out = 1'b1;
          bus.ir_in   = 1'b1;
        end
        ST_T3: begin
          if (is_alu(opcode)) begin
            r_out_c  = rb_sel;
            bus.y_in = 1'b1;
          end else if (is_muldiv(opcode)) begin
            r_out_c  = ra_sel;
            bus.y_in = 1'b1;
          end else if (opcode != OP_NOP && opcode != OP_HALT) begin
            bus.illegal = 1'b1;
          end
        end
        ST_T4: begin
          op_c       = opcode;
          bus.zlo_in = 1'b1;
          if (is_muldiv(opcode)) begin
            r_out_c    = rb_sel;
            bus.zhi_in = 1'b1;
          end else begin
            r_out_c = rc_sel;
          end
        end
        ST_T5: begin
          bus.zlo_out = 1'b1;
          if (is_muldiv(opcode)) bus.lo_in = 1'b1;
          else                   r_in_c    = ra_sel;
        end
        ST_T6: begin
          bus.zhi_out = 1'b1;
          bus.hi_in   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.r_in    = NREG'(r_in_c);
  assign bus.r_out   = NREG'(r_out_c);
  assign bus.op_code = OPW'(op_c);

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  control_sequencer_if #(.NREG(16), .OPW(5)) bus ();

  control_sequencer #(.NREG(16), .OPW(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Strobe vector bit positions (MSB first in strb())
  localparam logic [16:0] PC_OUT   = 17'h1 << 16;
  localparam logic [16:0] PC_IN    = 17'h1 << 15;
  localparam logic [16:0] PC_INC   = 17'h1 << 14;
  localparam logic [16:0] MAR_IN   = 17'h1 << 13;
  localparam logic [16:0] MDR_IN   = 17'h1 << 12;
  localparam logic [16:0] MDR_OUT  = 17'h1 << 11;
  localparam logic [16:0] MDR_READ = 17'h1 << 10;
  localparam logic [16:0] IR_IN    = 17'h1 << 9;
  localparam logic [16:0] Y_IN     = 17'h1 << 8;
  localparam logic [16:0] ZLO_IN   = 17'h1 << 7;
  localparam logic [16:0] ZHI_IN   = 17'h1 << 6;
  localparam logic [16:0] ZLO_OUT  = 17'h1 << 5;
  localparam logic [16:0] ZHI_OUT  = 17'h1 << 4;
  localparam logic [16:0] HI_IN    = 17'h1 << 3;
  localparam logic [16:0] LO_IN    = 17'h1 << 2;
  localparam logic [16:0] RUN      = 17'h1 << 1;
  localparam logic [16:0] ILL      = 17'h1;

  localparam logic [16:0] S_T0  = PC_OUT | MAR_IN | PC_INC | ZLO_IN | RUN;
  localparam logic [16:0] S_T1  = ZLO_OUT | PC_IN | MDR_READ | RUN;
  localparam logic [16:0] S_T1W = MDR_READ | RUN;
  localparam logic [16:0] S_T2  = MDR_OUT | IR_IN | RUN;

  localparam logic [31:0] IR_SUB  = 32'h20228000;  // sub r0,r4,r5
  localparam logic [31:0] IR_MUL  = 32'h69180000;  // mul Ra=2, Rb=3
  localparam logic [31:0] IR_HALT = 32'hC8000000;
  localparam logic [31:0] IR_NOP  = 32'hC0000000;
  localparam logic [31:0] IR_BAD  = 32'hF8000000;  // opcode 11111

  function automatic logic [16:0] strb();
    return {bus.pc_out, bus.pc_in, bus.pc_inc, bus.mar_in, bus.mdr_in,
            bus.mdr_out, bus.mdr_read, bus.ir_in, bus.y_in, bus.zlo_in,
            bus.zhi_in, bus.zlo_out, bus.zhi_out, bus.hi_in, bus.lo_in,
            bus.run, bus.illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_out(input string tag, input logic [16:0] es,
                           input logic [15:0] ein, input logic [15:0] eout,
                           input logic [4:0] eop);
    chk({tag, "_strb"},  32'(strb()),      32'(es));
    chk({tag, "_r_in"},  32'(bus.r_in),    32'(ein));
    chk({tag, "_r_out"}, 32'(bus.r_out),   32'(eout));
    chk({tag, "_op"},    32'(bus.op_code), 32'(eop));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // At most one bus driver in every cycle
  always @(negedge clk) begin
    n_assert++;
    assert ($onehot0({bus.r_out, bus.pc_out, bus.mdr_out, bus.zlo_out, bus.zhi_out})) else begin
      n_fail++;
      $error("FAIL bus_onehot observed=%0h expected=onehot0",
             {bus.r_out, bus.pc_out, bus.mdr_out, bus.zlo_out, bus.zhi_out});
    end
  end

  initial begin
    reset_n       = 1'b0;
    bus.start     = 1'b1;
    bus.mem_ready = 1'b1;
    bus.ir        = IR_SUB;

    // Reset held for two edges with start=1
    tick();
    check_out("rst1", '0, '0, '0, '0);
    tick();
    check_out("rst2", '0, '0, '0, '0);
    reset_n = 1'b1;
    #1;
    check_out("idle", '0, '0, '0, '0);

    // sub r0,r4,r5 with zero-wait memory
    tick(); check_out("sub_t0", S_T0, '0, '0, '0);
    bus.start = 1'b0;
    tick(); check_out("sub_t1",  S_T1, '0, '0, '0);
    tick(); check_out("sub_t1w", S_T1W | MDR_IN, '0, '0, '0);
    tick(); check_out("sub_t2",  S_T2, '0, '0, '0);
    tick(); check_out("sub_t3",  Y_IN | RUN, '0, 16'h0010, '0);
    tick(); check_out("sub_t4",  ZLO_IN | RUN, '0, 16'h0020, 5'b00100);
    tick(); check_out("sub_t5",  ZLO_OUT | RUN, 16'h0001, '0, '0);
    tick(); check_out("sub_next_t0", S_T0, '0, '0, '0);

    // Three wait cycles in T1W
    bus.mem_ready = 1'b0;
    bus.start     = 1'b1;  // ignored outside IDLE
    tick(); check_out("wt_t1", S_T1, '0, '0, '0);
    tick(); check_out("wt_w1", S_T1W, '0, '0, '0);
    tick(); check_out("wt_w2", S_T1W, '0, '0, '0);
    tick(); check_out("wt_w3", S_T1W, '0, '0, '0);
    bus.mem_ready = 1'b1;
    #1;
    check_out("wt_w4", S_T1W | MDR_IN, '0, '0, '0);
    bus.start = 1'b0;
    tick(); check_out("wt_t2", S_T2, '0, '0, '0);
    bus.ir = IR_MUL;  // IR only consulted from T3

    // mul Ra=2, Rb=3
    tick(); check_out("mul_t3", Y_IN | RUN, '0, 16'h0004, '0);
    tick(); check_out("mul_t4", ZLO_IN | ZHI_IN | RUN, '0, 16'h0008, 5'b01101);
    tick(); check_out("mul_t5", ZLO_OUT | LO_IN | RUN, '0, '0, '0);
    tick(); check_out("mul_t6", ZHI_OUT | HI_IN | RUN, '0, '0, '0);
    tick(); check_out("mul_t0", S_T0, '0, '0, '0);

    // nop
    bus.ir = IR_NOP;
    tick(); tick(); tick();
    check_out("nop_t2", S_T2, '0, '0, '0);
    tick(); check_out("nop_t3", RUN, '0, '0, '0);
    tick(); check_out("nop_t0", S_T0, '0, '0, '0);

    // halt
    bus.ir = IR_HALT;
    tick(); tick(); tick();
    tick(); check_out("halt_t3", RUN, '0, '0, '0);
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out("halt", '0, '0, '0, '0);
    end

    // Recover via reset, then undefined opcode
    reset_n = 1'b0;
    tick(); check_out("rst3", '0, '0, '0, '0);
    reset_n = 1'b1;
    bus.ir  = IR_BAD;
    tick(); check_out("ill_t0", S_T0, '0, '0, '0);
    bus.start = 1'b0;
    tick(); tick(); tick();
    check_out("ill_t2", S_T2, '0, '0, '0);
    tick(); check_out("ill_t3", ILL | RUN, '0, '0, '0);
    tick(); check_out("ill_t0b", S_T0, '0, '0, '0);

    // Reset asserted during T4
    bus.ir = IR_SUB;
    tick(); tick(); tick(); tick();
    check_out("rt4_t3", Y_IN | RUN, '0, 16'h0010, '0);
    tick(); check_out("rt4_t4", ZLO_IN | RUN, '0, 16'h0020, 5'b00100);
    reset_n = 1'b0;
    #1;
    check_out("rt4_hold", '0, '0, '0, '0);
    tick(); check_out("rt4_idle", '0, '0, '0, '0);
    reset_n = 1'b1;
    tick(); check_out("rt4_idle2", '0, '0, '0, '0);
    bus.start = 1'b1;
    tick(); check_out("rs_t0", S_T0, '0, '0, '0);
    bus.start = 1'b0;
    tick(); check_out("rs_t1", S_T1, '0, '0, '0);
    tick(); check_out("rs_t1w", S_T1W | MDR_IN, '0, '0, '0);
    tick(); check_out("rs_t2", S_T2, '0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
